// File: rtl/enet_nios_rx_pkg.sv
// Shared types and constants for the enet_nios MII receive path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package enet_nios_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_LOW_NIB,
        ST_HIGH_NIB,
        ST_DROP
    } rx_state_e;

    localparam logic [3:0] NIB_PREAMBLE = 4'h5;
    localparam logic [3:0] NIB_SFD      = 4'hD;

    // FIFO entry layout: {eof, err, byte[7:0]}
    localparam int EOF_BIT = 9;
    localparam int ERR_BIT = 8;
    localparam int ENTRY_W = 10;

endpackage

// File: rtl/enet_nios_mii_rx_assembler_if.sv
// Bundles the MII nibble inputs, FIFO read port and status of the rx assembler.
// Latency: n/a (wiring only).
// Backpressure: consumer pops with rd_en while rd_valid; the MII side has none.
// slave  : assembler view (MII and rd_en/clr_ovf in; rd_data/rd_valid/overflow/frame_cnt out)
// master : driver/consumer view (mirror image)
interface enet_nios_mii_rx_assembler_if;
    import enet_nios_rx_pkg::*;

    logic               nib_en;
    logic               mii_rx_dv;
    logic [3:0]         mii_rxd;
    logic               mii_rx_er;
    logic               rd_en;
    logic [ENTRY_W-1:0] rd_data;
    logic               rd_valid;
    logic               clr_ovf;
    logic               overflow;
    logic [7:0]         frame_cnt;

    modport slave (
        input  nib_en, mii_rx_dv, mii_rxd, mii_rx_er, rd_en, clr_ovf,
        output rd_data, rd_valid, overflow, frame_cnt
    );

    modport master (
        output nib_en, mii_rx_dv, mii_rxd, mii_rx_er, rd_en, clr_ovf,
        input  rd_data, rd_valid, overflow, frame_cnt
    );

endinterface

// File: rtl/enet_nios_rx_fifo.sv
// Synchronous show-ahead FIFO holding assembled receive entries.
// Latency: push at N visible at pop_data at N+1; pop_data is the head with no read latency.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
// Ports: clk, reset_n (sync, active-low), push/push_data, pop/pop_data, empty, full.
module enet_nios_rx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int W      = 10
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         empty,
    output logic         full
);

    logic [W-1:0]      mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic              do_push;
    logic              do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (ADDR_W+1)'(DEPTH));
    assign do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot the push is about to use.
    assign do_push  = push && (!full || do_pop);
    // Drive zero rather than stale storage while empty.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/enet_nios_mii_rx_assembler.sv
// MII receive front end: strips preamble/SFD, packs nibbles into bytes, tags eof/err, buffers them.
// Latency: byte k readable one cycle after byte k+1 completes; last byte one cycle after dv drops.
// Backpressure: none toward MII; a refused push drops the byte, sets sticky overflow, drops the frame.
// Ports: clk, reset_n (sync, active-low), rx (slave modport: MII in, FIFO read port, status out).
module enet_nios_mii_rx_assembler
    import enet_nios_rx_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = $clog2(FIFO_DEPTH)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    enet_nios_mii_rx_assembler_if.slave  rx
);

    rx_state_e          state;
    logic [7:0]         hold;
    logic               hold_valid;
    logic [3:0]         low_nib;
    logic               err_acc;
    logic               overflow_q;
    logic [7:0]         frame_cnt_q;

    logic               push_req;
    logic               push_ok;
    logic               refused;
    logic [ENTRY_W-1:0] push_dat;
    logic               fifo_empty;
    logic               fifo_full;

    // The held byte goes out when the next byte completes (eof=0) or when the
    // frame ends (eof=1). Ending on a high nibble means a dribble nibble: err.
    always_comb begin
        push_req = 1'b0;
        push_dat = '0;
        if (rx.nib_en && hold_valid) begin
            case (state)
                ST_LOW_NIB: begin
                    if (!rx.mii_rx_dv) begin
                        push_req          = 1'b1;
                        push_dat[7:0]     = hold;
                        push_dat[EOF_BIT] = 1'b1;
                        push_dat[ERR_BIT] = err_acc;
                    end
                end
                ST_HIGH_NIB: begin
                    push_req          = 1'b1;
                    push_dat[7:0]     = hold;
                    push_dat[EOF_BIT] = !rx.mii_rx_dv;
                    push_dat[ERR_BIT] = err_acc || !rx.mii_rx_dv;
                end
                default: ;
            endcase
        end
    end

    assign push_ok = push_req && (!fifo_full || (rx.rd_en && rx.rd_valid));
    assign refused = push_req && !push_ok;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            hold        <= '0;
            hold_valid  <= 1'b0;
            low_nib     <= '0;
            err_acc     <= 1'b0;
            overflow_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            // Set wins over clear so a refusal is never lost.
            if (refused)          overflow_q <= 1'b1;
            else if (rx.clr_ovf)  overflow_q <= 1'b0;

            if (push_ok && push_dat[EOF_BIT]) frame_cnt_q <= frame_cnt_q + 8'd1;

            if (rx.nib_en) begin
                case (state)
                    ST_IDLE: begin
                        if (rx.mii_rx_dv)
                            state <= (rx.mii_rxd == NIB_PREAMBLE) ? ST_PREAMBLE : ST_DROP;
                    end
                    ST_PREAMBLE: begin
                        if (!rx.mii_rx_dv) begin
                            state <= ST_IDLE;
                        end else if (rx.mii_rxd == NIB_SFD) begin
                            state   <= ST_LOW_NIB;
                            err_acc <= 1'b0;
                        end else if (rx.mii_rxd != NIB_PREAMBLE) begin
                            state <= ST_DROP;
                        end
                    end
                    ST_LOW_NIB: begin
                        err_acc <= err_acc | rx.mii_rx_er;
                        if (rx.mii_rx_dv) begin
                            low_nib <= rx.mii_rxd;
                            state   <= ST_HIGH_NIB;
                        end else begin
                            hold_valid <= 1'b0;
                            state      <= ST_IDLE;
                        end
                    end
                    ST_HIGH_NIB: begin
                        err_acc <= err_acc | rx.mii_rx_er;
                        if (rx.mii_rx_dv) begin
                            hold       <= {rx.mii_rxd, low_nib};
                            hold_valid <= 1'b1;
                            state      <= ST_LOW_NIB;
                        end else begin
                            hold_valid <= 1'b0;
                            state      <= ST_IDLE;
                        end
                    end
                    ST_DROP: begin
                        if (!rx.mii_rx_dv) state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase

                // A refused push truncates the frame; later assignments win.
                if (refused) begin
                    hold_valid <= 1'b0;
                    state      <= ST_DROP;
                end
            end
        end
    end

    enet_nios_rx_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .ADDR_W (ADDR_W),
        .W      (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push_ok),
        .push_data (push_dat),
        .pop       (rx.rd_en),
        .pop_data  (rx.rd_data),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign rx.rd_valid  = !fifo_empty;
    assign rx.overflow  = overflow_q;
    assign rx.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_enet_nios_mii_rx_assembler.sv
// Self-checking bench for enet_nios_mii_rx_assembler (FIFO_DEPTH=4).
// Latency: n/a.
// Backpressure: consumer pops are driven explicitly by the bench.
module tb_enet_nios_mii_rx_assembler;
    import enet_nios_rx_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    enet_nios_mii_rx_assembler_if rx();

    enet_nios_mii_rx_assembler #(.FIFO_DEPTH(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .rx      (rx)
    );

    int n_chk = 0;
    int n_err = 0;
    int fc_exp = 0;
    logic [9:0] sb [$];

    typedef struct {
        string       name;
        logic [63:0] nibs;   // nibble i at [4i +: 4], sent first to last
        int          n;
        int          er_at;  // nibble index carrying mii_rx_er, -1 for none
        bit          gap;    // insert an unqualified cycle before every nibble
        logic [39:0] exps;   // expected entry j at [10j +: 10]
        int          n_exp;
    } vec_t;

    vec_t tv [7];

    function automatic vec_t mk(string nm, logic [63:0] nb, int n, int er, bit g,
                                logic [39:0] ex, int ne);
        vec_t v;
        v.name = nm; v.nibs = nb; v.n = n; v.er_at = er; v.gap = g;
        v.exps = ex; v.n_exp = ne;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of stimulus; with rd=1 the head entry is checked against the scoreboard and popped.
    task automatic drive(input bit en, input bit dv, input logic [3:0] d, input bit er, input bit rd);
        rx.nib_en    = en;
        rx.mii_rx_dv = dv;
        rx.mii_rxd   = d;
        rx.mii_rx_er = er;
        if (rd) begin
            chk("pop_valid", int'(rx.rd_valid), 1);
            if (rx.rd_valid) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL pop_extra: DUT entry 0x%0h, none expected", rx.rd_data);
                end else begin
                    chk("pop_data", int'(rx.rd_data), int'(sb.pop_front()));
                end
            end
            rx.rd_en = 1'b1;
        end
        tick();
        rx.rd_en  = 1'b0;
        rx.nib_en = 1'b0;
    endtask

    task automatic nib(input bit dv, input logic [3:0] d, input bit er, input bit rd, input bit gap);
        if (gap) drive(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                       1'($urandom_range(0, 1)), 1'b0);
        drive(1'b1, dv, d, er, rd);
    endtask

    task automatic send_frame(input logic [63:0] nibs, input int n, input int er_at, input bit gap);
        for (int i = 0; i < 7; i++) nib(1'b1, NIB_PREAMBLE, 1'b0, 1'b0, gap);
        nib(1'b1, NIB_SFD, 1'b0, 1'b0, gap);
        for (int i = 0; i < n; i++) nib(1'b1, nibs[4*i +: 4], (i == er_at), 1'b0, gap);
        nib(1'b0, 4'h0, 1'b0, 1'b0, gap);
    endtask

    task automatic drain();
        for (int k = 0; k < 16 && rx.rd_valid; k++) drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
        chk("sb_empty", sb.size(), 0);
        chk("fifo_empty", int'(rx.rd_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] nb;

        tv[0] = mk("basic",     64'h0F4321, 6, -1, 1'b0, {10'h0, 10'h20F, 10'h043, 10'h021}, 3);
        tv[1] = mk("err_mid",   64'h0F4321, 6,  2, 1'b0, {10'h0, 10'h30F, 10'h143, 10'h121}, 3);
        tv[2] = mk("odd",       64'h321,    3, -1, 1'b0, {10'h0, 10'h0, 10'h0, 10'h321}, 1);
        tv[3] = mk("zero_len",  64'h0,      0, -1, 1'b0, 40'h0, 0);
        tv[4] = mk("one_byte",  64'hA5,     2, -1, 1'b0, {10'h0, 10'h0, 10'h0, 10'h2A5}, 1);
        tv[5] = mk("err_first", 64'h8877,   4,  0, 1'b0, {10'h0, 10'h0, 10'h388, 10'h177}, 2);
        tv[6] = mk("gapped",    64'h0F4321, 6, -1, 1'b1, {10'h0, 10'h20F, 10'h043, 10'h021}, 3);

        rx.nib_en = 0; rx.mii_rx_dv = 0; rx.mii_rxd = 0; rx.mii_rx_er = 0;
        rx.rd_en = 0; rx.clr_ovf = 0;
        reset_n = 1'b0;
        tick(); tick();
        chk("rst_rd_valid",  int'(rx.rd_valid), 0);
        chk("rst_rd_data",   int'(rx.rd_data), 0);
        chk("rst_overflow",  int'(rx.overflow), 0);
        chk("rst_frame_cnt", int'(rx.frame_cnt), 0);
        reset_n = 1'b1;
        tick();

        // Table-driven frames.
        foreach (tv[i]) begin
            for (int j = 0; j < tv[i].n_exp; j++) sb.push_back(tv[i].exps[10*j +: 10]);
            if (tv[i].n_exp > 0) fc_exp++;
            send_frame(tv[i].nibs, tv[i].n, tv[i].er_at, tv[i].gap);
            chk({tv[i].name, "_ovf"}, int'(rx.overflow), 0);
            chk({tv[i].name, "_fcnt"}, int'(rx.frame_cnt), fc_exp);
            drain();
        end

        // Fill to full, then push while popping in the same cycle.
        sb.push_back(10'h011); sb.push_back(10'h022); sb.push_back(10'h033); sb.push_back(10'h244);
        send_frame(64'h44332211, 8, -1, 1'b0);
        fc_exp++;
        chk("full_fcnt", int'(rx.frame_cnt), fc_exp);
        for (int i = 0; i < 7; i++) nib(1'b1, NIB_PREAMBLE, 1'b0, 1'b0, 1'b0);
        nib(1'b1, NIB_SFD, 1'b0, 1'b0, 1'b0);
        nib(1'b1, 4'h5, 1'b0, 1'b0, 1'b0);
        nib(1'b1, 4'h5, 1'b0, 1'b0, 1'b0);
        nib(1'b1, 4'h6, 1'b0, 1'b0, 1'b0);
        sb.push_back(10'h055);
        nib(1'b1, 4'h6, 1'b0, 1'b1, 1'b0);
        sb.push_back(10'h266);
        nib(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        fc_exp++;
        chk("popfull_ovf", int'(rx.overflow), 0);
        chk("popfull_fcnt", int'(rx.frame_cnt), fc_exp);
        drain();

        // Overflow: 8-byte frame into a 4-entry FIFO with no pops.
        for (int k = 0; k < 8; k++) nb[8*k +: 8] = 8'h80 + 8'(k);
        for (int k = 0; k < 4; k++) sb.push_back(10'h080 + 10'(k));
        send_frame(nb, 16, -1, 1'b0);
        chk("ovf_set", int'(rx.overflow), 1);
        chk("ovf_fcnt", int'(rx.frame_cnt), fc_exp);
        drain();
        chk("ovf_sticky", int'(rx.overflow), 1);
        rx.clr_ovf = 1'b1;
        tick();
        rx.clr_ovf = 1'b0;
        chk("ovf_cleared", int'(rx.overflow), 0);
        for (int j = 0; j < tv[0].n_exp; j++) sb.push_back(tv[0].exps[10*j +: 10]);
        fc_exp++;
        send_frame(tv[0].nibs, tv[0].n, -1, 1'b0);
        chk("post_ovf_fcnt", int'(rx.frame_cnt), fc_exp);
        drain();

        // Reset in the middle of a payload.
        for (int i = 0; i < 7; i++) nib(1'b1, NIB_PREAMBLE, 1'b0, 1'b0, 1'b0);
        nib(1'b1, NIB_SFD, 1'b0, 1'b0, 1'b0);
        nib(1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
        nib(1'b1, 4'h2, 1'b0, 1'b0, 1'b0);
        nib(1'b1, 4'h3, 1'b0, 1'b0, 1'b0);
        nib(1'b1, 4'h4, 1'b0, 1'b0, 1'b0);
        chk("midrst_pre_valid", int'(rx.rd_valid), 1);
        rx.nib_en = 1'b1; rx.mii_rx_dv = 1'b1; rx.mii_rxd = 4'hF;
        reset_n = 1'b0;
        tick();
        chk("midrst_rd_valid",  int'(rx.rd_valid), 0);
        chk("midrst_rd_data",   int'(rx.rd_data), 0);
        chk("midrst_overflow",  int'(rx.overflow), 0);
        chk("midrst_frame_cnt", int'(rx.frame_cnt), 0);
        reset_n = 1'b1;
        rx.nib_en = 1'b0;
        sb.delete();
        // No preamble: must drop until dv falls, even though a preamble/SFD follows.
        nib(1'b1, 4'h3, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) nib(1'b1, NIB_PREAMBLE, 1'b0, 1'b0, 1'b0);
        nib(1'b1, NIB_SFD, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) nib(1'b1, 4'(i), 1'b0, 1'b0, 1'b0);
        nib(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("drop_rd_valid", int'(rx.rd_valid), 0);
        chk("drop_frame_cnt", int'(rx.frame_cnt), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
